// File: rtl/life_gen_sched.sv
// life_gen_sched - schedules Life PE array generation updates against the video scan.
//
// Watches the scan position and, at the first cycle of vertical blanking, issues a
// one-cycle pe_step to the PE array when a generation is due (single-step request
// pending, or free-running and enough frames have elapsed). While the array is
// updating, display reads are gated off. Completed generations are counted, and an
// update that is still running when active video restarts raises a sticky overrun.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   x, y            current scan position (11 bits each)
//   run             level: free-running generations
//   step_req        pulse: request one generation
//   speed           frames per generation minus 1 while running
//   pe_done         pulse from PE array: update finished
//   clr_overrun     pulse: clear the overrun flag (and counter when present)
//   pe_step         pulse to PE array: compute next generation
//   disp_en         1 = cell state valid for display, 0 = force black
//   updating        1 while an update is in progress
//   gen_count       completed generations (wraps)
//   overrun         sticky: update ran into active video
//   overrun_cnt     (only with LIFE_OVERRUN_CNT_EN) frames with an overrun, saturating
//
// Optional feature macro: LIFE_OVERRUN_CNT_EN
module life_gen_sched #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int GEN_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         x,
  input  logic [10:0]         y,
  input  logic                run,
  input  logic                step_req,
  input  logic [3:0]          speed,
  input  logic                pe_done,
  input  logic                clr_overrun,
  output logic                pe_step,
  output logic                disp_en,
  output logic                updating,
  output logic [GEN_BITS-1:0] gen_count,
`ifdef LIFE_OVERRUN_CNT_EN
  output logic [7:0]          overrun_cnt,
`endif
  output logic                overrun
);

  typedef enum logic [0:0] {DISPLAY = 1'b0, UPDATE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                pe_step_q, pe_step_d;
  logic                disp_en_q, disp_en_d;
  logic                updating_q, updating_d;
  logic [GEN_BITS-1:0] gen_count_q, gen_count_d;
  logic                overrun_q, overrun_d;
  logic [3:0]          frame_cnt_q, frame_cnt_d;
  logic                step_pending_q, step_pending_d;
  logic                line_start_s;
  logic                blank_start_s;
  logic                active_start_s;
  logic                go_s;
  logic                ovr_set_s;
`ifdef LIFE_OVERRUN_CNT_EN
  logic [7:0]          overrun_cnt_q, overrun_cnt_d;
`endif

  // Pixel 0 is the first visible pixel of a line; a zero-width raster has none.
  assign line_start_s   = (x == 11'd0) && (H_ACTIVE > 0);
  assign blank_start_s  = line_start_s && (y == 11'(V_ACTIVE));
  assign active_start_s = line_start_s && (y == 11'd0);
  // ">=" so that lowering speed mid-count steps at the very next blank.
  assign go_s = step_pending_q || (run && (frame_cnt_q >= speed));

  // Next-state and next-output computation for the scheduler.
  always_comb begin
    state_d        = state_q;
    pe_step_d      = 1'b0;
    disp_en_d      = disp_en_q;
    updating_d     = updating_q;
    gen_count_d    = gen_count_q;
    frame_cnt_d    = frame_cnt_q;
    step_pending_d = step_pending_q | step_req;
    ovr_set_s      = 1'b0;
    case (state_q)
      DISPLAY: begin
        disp_en_d  = 1'b1;
        updating_d = 1'b0;
        if (blank_start_s) begin
          if (go_s) begin
            pe_step_d      = 1'b1;
            frame_cnt_d    = 4'd0;
            step_pending_d = 1'b0;  // a step_req in this same cycle is dropped
            state_d        = UPDATE;
            disp_en_d      = 1'b0;
            updating_d     = 1'b1;
          end else if (run && (frame_cnt_q != 4'd15)) begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end
      UPDATE: begin
        disp_en_d  = 1'b0;
        updating_d = 1'b1;
        // Completion takes priority over an overrun on the same cycle.
        if (pe_done) begin
          gen_count_d = gen_count_q + GEN_BITS'(1);
          state_d     = DISPLAY;
          disp_en_d   = 1'b1;
          updating_d  = 1'b0;
        end else if (active_start_s) begin
          ovr_set_s = 1'b1;
        end else begin
          state_d = UPDATE;
        end
      end
      default: begin
        state_d    = DISPLAY;
        disp_en_d  = 1'b1;
        updating_d = 1'b0;
      end
    endcase

    // Set wins over clear.
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

`ifdef LIFE_OVERRUN_CNT_EN
    // A clear coinciding with a new overrun leaves exactly that one counted.
    if (ovr_set_s && clr_overrun) begin
      overrun_cnt_d = 8'd1;
    end else if (clr_overrun) begin
      overrun_cnt_d = 8'd0;
    end else if (ovr_set_s && (overrun_cnt_q != 8'd255)) begin
      overrun_cnt_d = overrun_cnt_q + 8'd1;
    end else begin
      overrun_cnt_d = overrun_cnt_q;
    end
`endif
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= DISPLAY;
      pe_step_q      <= 1'b0;
      disp_en_q      <= 1'b1;
      updating_q     <= 1'b0;
      gen_count_q    <= '0;
      overrun_q      <= 1'b0;
      frame_cnt_q    <= 4'd0;
      step_pending_q <= 1'b0;
`ifdef LIFE_OVERRUN_CNT_EN
      overrun_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q        <= state_d;
      pe_step_q      <= pe_step_d;
      disp_en_q      <= disp_en_d;
      updating_q     <= updating_d;
      gen_count_q    <= gen_count_d;
      overrun_q      <= overrun_d;
      frame_cnt_q    <= frame_cnt_d;
      step_pending_q <= step_pending_d;
`ifdef LIFE_OVERRUN_CNT_EN
      overrun_cnt_q  <= overrun_cnt_d;
`endif
    end
  end

  assign pe_step   = pe_step_q;
  assign disp_en   = disp_en_q;
  assign updating  = updating_q;
  assign gen_count = gen_count_q;
  assign overrun   = overrun_q;
`ifdef LIFE_OVERRUN_CNT_EN
  assign overrun_cnt = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_life_gen_sched.sv
// Directed testbench for life_gen_sched with hand-computed expectations.
module tb_life_gen_sched;

  logic        clk;
  logic        rst;
  logic [10:0] x;
  logic [10:0] y;
  logic        run;
  logic        step_req;
  logic [3:0]  speed;
  logic        pe_done;
  logic        clr_overrun;
  logic        pe_step;
  logic        disp_en;
  logic        updating;
  logic [15:0] gen_count;
  logic        overrun;
`ifdef LIFE_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_gen = 0;
  int low_cnt;
  int step_cnt;

  life_gen_sched dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .run         (run),
    .step_req    (step_req),
    .speed       (speed),
    .pe_done     (pe_done),
    .clr_overrun (clr_overrun),
    .pe_step     (pe_step),
    .disp_en     (disp_en),
    .updating    (updating),
    .gen_count   (gen_count),
`ifdef LIFE_OVERRUN_CNT_EN
    .overrun_cnt (overrun_cnt),
`endif
    .overrun     (overrun)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_pos();
    x = 11'd5;
    y = 11'd770;
  endtask

  // One cycle at the first blanking line's pixel 0, then check pe_step.
  task automatic blank_pulse(input string tag, input int exp_step);
    x = 11'd0;
    y = 11'd768;
    cyc();
    idle_pos();
    check_eq(tag, int'(pe_step), exp_step);
  endtask

  task automatic done_pulse();
    pe_done = 1'b1;
    cyc();
    pe_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step_req = 1'b0; speed = 4'd0;
    pe_done = 1'b0; clr_overrun = 1'b0;
    idle_pos();
    cyc(); cyc();
    rst = 1'b0;
    check_eq("rst_pe_step", int'(pe_step), 0);
    check_eq("rst_disp_en", int'(disp_en), 1);
    check_eq("rst_updating", int'(updating), 0);
    check_eq("rst_gen", int'(gen_count), 0);
    check_eq("rst_overrun", int'(overrun), 0);

    // Single step with run=0, slow update (100 cycles display off).
    y = 11'd100;
    step_req = 1'b1; cyc(); step_req = 1'b0;
    step_req = 1'b1; cyc(); step_req = 1'b0;  // collapses into one
    cyc(); cyc();
    check_eq("ss_no_early_step", int'(pe_step), 0);
    blank_pulse("ss_step", 1);
    check_eq("ss_updating", int'(updating), 1);
    low_cnt = (disp_en == 1'b0) ? 1 : 0;
    for (int i = 0; i < 99; i++) begin
      cyc();
      if (disp_en == 1'b0) low_cnt++;
    end
    check_eq("ss_disp_low_cycles", low_cnt, 100);
    done_pulse();
    exp_gen++;
    check_eq("ss_disp_back", int'(disp_en), 1);
    check_eq("ss_gen", int'(gen_count), exp_gen);
    cyc();
    blank_pulse("ss_second_blank", 0);

    // Free run, speed=2: steps on frames 3, 6, 9.
    run = 1'b1; speed = 4'd2;
    step_cnt = 0;
    for (int f = 1; f <= 9; f++) begin
      blank_pulse($sformatf("fr_frame%0d", f), (f % 3 == 0) ? 1 : 0);
      if (pe_step) begin
        step_cnt++;
        done_pulse();
        exp_gen++;
      end
      cyc();
    end
    check_eq("fr_steps", step_cnt, 3);
    check_eq("fr_gen", int'(gen_count), exp_gen);

    // Overrun: speed=0, update runs past active_start.
    speed = 4'd0;
    blank_pulse("ov_step", 1);
    cyc();
    x = 11'd0; y = 11'd0; cyc(); idle_pos();
    check_eq("ov_flag", int'(overrun), 1);
    check_eq("ov_disp_off", int'(disp_en), 0);
`ifdef LIFE_OVERRUN_CNT_EN
    check_eq("ov_cnt", int'(overrun_cnt), 1);
`endif
    cyc();
    check_eq("ov_disp_still_off", int'(disp_en), 0);
    blank_pulse("ov_blank_ignored", 0);
    done_pulse();
    exp_gen++;
    check_eq("ov_disp_after_done", int'(disp_en), 1);
    blank_pulse("ov_next_step", 1);
    done_pulse();
    exp_gen++;
    check_eq("ov_sticky", int'(overrun), 1);
    clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
    check_eq("ov_cleared", int'(overrun), 0);
`ifdef LIFE_OVERRUN_CNT_EN
    check_eq("ov_cnt_cleared", int'(overrun_cnt), 0);
`endif

    // pe_done coincident with active_start: no overrun.
    blank_pulse("co_step", 1);
    cyc();
    x = 11'd0; y = 11'd0; pe_done = 1'b1; cyc(); pe_done = 1'b0; idle_pos();
    exp_gen++;
    check_eq("co_no_overrun", int'(overrun), 0);
    check_eq("co_disp_en", int'(disp_en), 1);
    check_eq("co_gen", int'(gen_count), exp_gen);

    // Overrun set and clear in the same cycle: set wins.
    blank_pulse("sc_step", 1);
    x = 11'd0; y = 11'd0; clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0; idle_pos();
    check_eq("sc_set_wins", int'(overrun), 1);
`ifdef LIFE_OVERRUN_CNT_EN
    check_eq("sc_cnt_one", int'(overrun_cnt), 1);
`endif
    done_pulse();
    exp_gen++;
    clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;

    // speed=15, frame_cnt reaches 5, then speed lowered to 3.
    speed = 4'd15;
    for (int f = 1; f <= 5; f++) begin
      blank_pulse($sformatf("sp_wait%0d", f), 0);
      cyc();
    end
    speed = 4'd3;
    blank_pulse("sp_lowered_step", 1);
    done_pulse();
    exp_gen++;
    check_eq("sp_gen", int'(gen_count), exp_gen);

    // Reset in UPDATE, then stray pe_done.
    speed = 4'd0;
    blank_pulse("rs_step", 1);
    check_eq("rs_updating", int'(updating), 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check_eq("rs_disp_en", int'(disp_en), 1);
    check_eq("rs_updating_off", int'(updating), 0);
    check_eq("rs_gen", int'(gen_count), 0);
    done_pulse();
    cyc();
    check_eq("rs_stray_done_gen", int'(gen_count), 0);
    check_eq("rs_stray_done_disp", int'(disp_en), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
